// File: rtl/tdelay_meter_pkg.sv
// Shared types and default sizing for the trigger-to-target delay meter.
package tdelay_meter_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_TRIG = 2'd1,
      WAIT_TARG = 2'd2,
      DONE      = 2'd3
   } state_t;

   localparam int DEF_CNT_W       = 16;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/tdelay_meter_sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous input followed by a
// previous-value register that yields single-cycle rise/fall strobes.
module sync_edge_det
   import tdelay_meter_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/tdelay_meter.sv
// Measures clk cycles from a selected trigger edge to a selected target edge.
// Optional TDELAY_METER_TIMEOUT_EN ends a measurement when the counter saturates.
module tdelay_meter
   import tdelay_meter_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             trig_fall_i,
   input  logic             targ_rise_i,
   input  logic             trig_i,
   input  logic             targ_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] delay_o,
   output logic             timeout_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             trig_fall_q;
   logic             targ_rise_q;
   logic             trig_rise_s, trig_fall_s;
   logic             targ_rise_s, targ_fall_s;
   logic             trig_edge, targ_edge;
   logic [CNT_W-1:0] cnt_next;

   // Identical synchroniser depth on both paths so their latency cancels.
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_trig (
      .clk (clk),
      .rst (rst),
      .din (trig_i),
      .rise(trig_rise_s),
      .fall(trig_fall_s)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_targ (
      .clk (clk),
      .rst (rst),
      .din (targ_i),
      .rise(targ_rise_s),
      .fall(targ_fall_s)
   );

   assign trig_edge = trig_fall_q ? trig_fall_s : trig_rise_s;
   assign targ_edge = targ_rise_q ? targ_rise_s : targ_fall_s;
   assign cnt_next  = sat_inc(cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         trig_fall_q <= 1'b0;
         targ_rise_q <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         delay_o     <= '0;
         timeout_o   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  trig_fall_q <= trig_fall_i;
                  targ_rise_q <= targ_rise_i;
                  cnt         <= '0;
                  delay_o     <= '0;
                  timeout_o   <= 1'b0;
                  busy_o      <= 1'b1;
                  state       <= WAIT_TRIG;
               end
            end
            WAIT_TRIG: begin
               if (trig_edge) begin
                  cnt   <= '0;
                  state <= WAIT_TARG;
               end
            end
            // cnt holds k-1 during cycle k after trigger detection.
            WAIT_TARG: begin
               if (targ_edge) begin
                  delay_o <= cnt_next;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
                  state   <= DONE;
`ifdef TDELAY_METER_TIMEOUT_EN
               end else if (cnt_next == CNT_MAX) begin
                  delay_o   <= CNT_MAX;
                  timeout_o <= 1'b1;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  state     <= DONE;
`endif
               end else begin
                  cnt <= cnt_next;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdelay_meter.sv
// Directed bench for tdelay_meter (CNT_W=8, SYNC_STAGES=2).
module tb_tdelay_meter;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i;
   logic             trig_fall_i;
   logic             targ_rise_i;
   logic             trig_i;
   logic             targ_i;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] delay_o;
   logic             timeout_o;

   int n_cmp = 0;
   int n_bad = 0;

   tdelay_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .trig_fall_i(trig_fall_i),
      .targ_rise_i(targ_rise_i),
      .trig_i     (trig_i),
      .targ_i     (targ_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .delay_o    (delay_o),
      .timeout_o  (timeout_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns number of ticks until done_o seen, or -1 if the budget expires.
   task automatic wait_done(input int max, output int n);
      int k;
      bit seen;
      k = 0;
      seen = 0;
      while (k < max && !seen) begin
         tick();
         k++;
         if (done_o === 1'b1) seen = 1;
      end
      n = seen ? k : -1;
   endtask

   task automatic do_start(input logic tf, input logic tr, input string tag);
      start_i     = 1'b1;
      trig_fall_i = tf;
      targ_rise_i = tr;
      tick();
      start_i = 1'b0;
      n_cmp++;
      if (busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_busy_after_start: got %b want 1", tag, busy_o);
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_cmp++;
      if ({busy_o, done_o, timeout_o} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_flags: got busy/done/to=%b%b%b want 000", busy_o, done_o, timeout_o);
      end
      n_cmp++;
      if (delay_o !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_delay: got %0d want 0", delay_o);
      end
      start_i = 1'b1;
      tick();
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_start_held: got busy %b want 0", busy_o);
      end
      start_i = 1'b0;
      rst = 1'b0;
      repeat (2) tick();
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_start_ignored: got busy %b want 0", busy_o);
      end
   endtask

   task automatic test_nominal();
      int n;
      trig_i = 1'b1;
      targ_i = 1'b0;
      repeat (5) tick();
      do_start(1'b1, 1'b1, "nom");
      repeat (10) tick();
      trig_i = 1'b0;
      repeat (37) tick();
      targ_i = 1'b1;
      wait_done(10, n);
      n_cmp++;
      if (n !== 3) begin
         n_bad++;
         $display("FAIL nom_done_latency: got %0d want 3", n);
      end
      n_cmp++;
      if (delay_o !== 8'd37) begin
         n_bad++;
         $display("FAIL nom_delay: got %0d want 37", delay_o);
      end
      n_cmp++;
      if ({busy_o, timeout_o} !== 2'b00) begin
         n_bad++;
         $display("FAIL nom_busy_to_at_done: got %b%b want 00", busy_o, timeout_o);
      end
      tick();
      n_cmp++;
      if (done_o !== 1'b0 || delay_o !== 8'd37) begin
         n_bad++;
         $display("FAIL nom_pulse_hold: got done %b delay %0d want 0 37", done_o, delay_o);
      end
   endtask

   task automatic test_polarity();
      int n;
      trig_i = 1'b1;
      targ_i = 1'b0;
      repeat (5) tick();
      do_start(1'b0, 1'b0, "pol");
      repeat (3) tick();
      trig_i = 1'b0;
      repeat (6) tick();
      n_cmp++;
      if (busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL pol_wrong_trig_edge: got busy %b want 1", busy_o);
      end
      trig_i = 1'b1;
      repeat (2) tick();
      targ_i = 1'b1;
      repeat (3) tick();
      targ_i = 1'b0;
      wait_done(10, n);
      n_cmp++;
      if (n !== 3 || delay_o !== 8'd5) begin
         n_bad++;
         $display("FAIL pol_delay: got n=%0d delay=%0d want 3 5", n, delay_o);
      end
   endtask

   task automatic test_simultaneous();
      int n;
      trig_i = 1'b0;
      targ_i = 1'b0;
      repeat (5) tick();
      do_start(1'b0, 1'b1, "sim");
      repeat (3) tick();
      trig_i = 1'b1;
      targ_i = 1'b1;
      tick();
      targ_i  = 1'b0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      targ_i = 1'b1;
      wait_done(10, n);
      n_cmp++;
      if (n !== 3 || delay_o !== 8'd3) begin
         n_bad++;
         $display("FAIL sim_delay: got n=%0d delay=%0d want 3 3", n, delay_o);
      end
      repeat (3) tick();
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL sim_start_during_busy: got busy %b want 0", busy_o);
      end
   endtask

   task automatic test_timeout();
      int n;
      int bad;
      trig_i = 1'b0;
      targ_i = 1'b0;
      repeat (5) tick();
      do_start(1'b0, 1'b1, "to");
      repeat (2) tick();
      trig_i = 1'b1;
`ifdef TDELAY_METER_TIMEOUT_EN
      wait_done(300, n);
      n_cmp++;
      if (n !== 258) begin
         n_bad++;
         $display("FAIL to_done_time: got %0d want 258", n);
      end
      n_cmp++;
      if (delay_o !== 8'd255 || timeout_o !== 1'b1 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL to_result: got delay %0d to %b busy %b want 255 1 0", delay_o, timeout_o, busy_o);
      end
`else
      bad = 0;
      repeat (1000) begin
         tick();
         if (busy_o !== 1'b1 || done_o !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL to_hold_busy: got %0d bad cycles want 0", bad);
      end
      targ_i = 1'b1;
      wait_done(10, n);
      n_cmp++;
      if (n !== 3 || delay_o !== 8'd255 || timeout_o !== 1'b0) begin
         n_bad++;
         $display("FAIL to_saturated: got n=%0d delay=%0d to=%b want 3 255 0", n, delay_o, timeout_o);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int n;
      trig_i = 1'b0;
      targ_i = 1'b0;
      repeat (5) tick();
      do_start(1'b0, 1'b1, "rm");
      repeat (2) tick();
      trig_i = 1'b1;
      repeat (20) tick();
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy_o, done_o, timeout_o} !== 3'b000 || delay_o !== 8'd0) begin
         n_bad++;
         $display("FAIL rm_async_clear: got busy %b done %b to %b delay %0d want 0 0 0 0",
                  busy_o, done_o, timeout_o, delay_o);
      end
      repeat (2) tick();
      rst = 1'b0;
      trig_i = 1'b0;
      repeat (5) tick();
      do_start(1'b0, 1'b1, "rm2");
      repeat (2) tick();
      trig_i = 1'b1;
      repeat (12) tick();
      targ_i = 1'b1;
      wait_done(10, n);
      n_cmp++;
      if (n !== 3 || delay_o !== 8'd12 || timeout_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rm_remeasure: got n=%0d delay=%0d to=%b want 3 12 0", n, delay_o, timeout_o);
      end
   endtask

   initial begin
      rst         = 1'b1;
      start_i     = 1'b0;
      trig_fall_i = 1'b0;
      targ_rise_i = 1'b0;
      trig_i      = 1'b0;
      targ_i      = 1'b0;
      test_reset();
      test_nominal();
      test_polarity();
      test_simultaneous();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
